flag_unit: RTL and testbench
============================

# flag_unit

Holds the architectural NZCV status register fed by the EX-stage ALU `status` output. Returns the current carry to the ALU and evaluates the 4-bit ARM condition field for the instruction in ID. A pending-writer counter tracks flag-setting instructions between issue and commit; ID is stalled until the flags its condition depends on are final. The unit sits between ID (condition check, issue) and EX (flag producer).

## Interface
- `MAX_INFLIGHT`, default 3: maximum outstanding flag-setting instructions between issue and commit; the counter width is `$clog2(MAX_INFLIGHT+1)`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `issue_valid` in 1: ID presents an instruction this cycle.
- `issue_sets_flags` in 1: that instruction has S=1.
- `cond` in 4: condition field of the instruction in ID.
- `commit_valid` in 1: a flag-setting instruction completes in EX this cycle.
- `alu_status` in 4: ALU flags, bit 3=N, bit 2=Z, bit 1=C, bit 0=V.
- `nzcv` out 4: registered flags, same bit order.
- `carry` out 1: `nzcv[1]`, fed to the ALU carry input.
- `cond_pass` out 1: condition holds; meaningful only when `stall`=0.
- `stall` out 1: ID must hold its instruction; the issue is not accepted.
- `err` out 1: sticky protocol error.

## Operation
- Effective flags: `eff = commit_valid ? alu_status : nzcv`. This forwards the committing flags in the same cycle.
- Remaining pending count: `rem = count - commit_valid`.
- `stall` asserts when either of these holds:
  - `rem != 0` and `cond != 4'b1110` (AL). Only AL is independent of in-flight writers.
  - `count == MAX_INFLIGHT`, `issue_sets_flags`, and `commit_valid == 0`. This is the counter-full case.
- Accepted issue: `acc = issue_valid & ~stall`.
- Counter update: `count_next = count + (acc & issue_sets_flags) - commit_valid`. Simultaneous increment and decrement leaves the count unchanged.
- On `commit_valid`: `nzcv <= alu_status`.
- On `commit_valid` while `count == 0`: `err` sets and stays set until reset. `nzcv` still updates and the count stays 0 (no wrap below zero).
- Condition evaluation uses `eff`:
  - EQ 0000: Z. NE 0001: !Z.
  - CS 0010: C. CC 0011: !C.
  - MI 0100: N. PL 0101: !N.
  - VS 0110: V. VC 0111: !V.
  - HI 1000: C&!Z. LS 1001: !C|Z.
  - GE 1010: N==V. LT 1011: N!=V.
  - GT 1100: !Z&(N==V). LE 1101: Z|(N!=V).
  - AL 1110: 1. 1111: 0 (treated as never).
- `cond_pass` and `stall` are combinational from the inputs, `count` and `nzcv`.

## Timing
- Reset values: `nzcv`=0000, `carry`=0, `count`=0, `err`=0.
  - After reset, `stall`=0 (except when `MAX_INFLIGHT`=0, which is not allowed).
  - After reset, `cond_pass` follows `cond` evaluated against 0000.
- Reset asserted mid-operation: all state clears immediately; in-flight writers are forgotten.
- Latency:
  - Committed flags are visible on `cond_pass` in the commit cycle (forwarded) and on `nzcv` and `carry` the cycle after.
  - An issued S-instruction blocks a dependent `cond` starting the next cycle.
- Handshake: ID holds `cond`, `issue_valid` and `issue_sets_flags` stable while `stall`=1. EX never stalls commits.

## Structure
- Shared package holds:
  - the `cond_e` 4-bit constants EQ..AL and NV;
  - the NZCV bit-index constants `N_BIT`=3, `Z_BIT`=2, `C_BIT`=1, `V_BIT`=0.
  - The ALU uses the same package.
- Sub-module `cond_eval`: combinational, maps (`cond`, `nzcv`) to a pass bit. It is reused by the branch logic.
- Top level holds the flag register, the pending counter, the forwarding mux and the stall logic.

## Test plan
- Reset, then `commit_valid`=1 with `alu_status`=0100 -> `err`=1 and `nzcv`=0100 on the next edge; `err` stays 1 until `rst`.
- Issue S-instruction (count 1); next cycle `cond`=EQ with no commit -> `stall`=1. Commit `alu_status`=0100 in a later cycle -> `stall`=0 and `cond_pass`=1 in that same cycle (forwarded).
- `cond`=AL with count=2 -> `stall`=0 and `cond_pass`=1; the count is unchanged unless the AL instruction sets flags.
- `MAX_INFLIGHT`=3: issue three S-instructions -> count=3. A fourth S-issue gives `stall`=1. The same fourth issue together with `commit_valid` -> accepted, count stays 3.
- Exercise all 16 `cond` values against NZCV patterns 0000, 0100, 1001, 0110 and 1111 -> `cond_pass` matches the table in Operation; 1111 always gives 0.
- Assert `rst` at count=2 -> count=0, `nzcv`=0000 and `stall`=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/flag_unit_pkg.sv
// Shared NZCV definitions: condition-field encodings and flag bit positions.
// Used by the flag unit, the condition evaluator and the ALU.
package flag_unit_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_e;

    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;

endpackage

// File: rtl/flag_unit_cond_eval.sv
// Combinational ARM condition check: maps (cond, nzcv) to a pass bit.
// Shared with the branch logic, so it carries no state.
module cond_eval
    import flag_unit_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_nzcv,
    output logic       o_pass
);

    logic w_n, w_z, w_c, w_v;

    assign w_n = i_nzcv[N_BIT];
    assign w_z = i_nzcv[Z_BIT];
    assign w_c = i_nzcv[C_BIT];
    assign w_v = i_nzcv[V_BIT];

    always_comb begin
        o_pass = 1'b0;
        case (cond_e'(i_cond))
            EQ:      o_pass = w_z;
            NE:      o_pass = ~w_z;
            CS:      o_pass = w_c;
            CC:      o_pass = ~w_c;
            MI:      o_pass = w_n;
            PL:      o_pass = ~w_n;
            VS:      o_pass = w_v;
            VC:      o_pass = ~w_v;
            HI:      o_pass = w_c & ~w_z;
            LS:      o_pass = ~w_c | w_z;
            GE:      o_pass = (w_n == w_v);
            LT:      o_pass = (w_n != w_v);
            GT:      o_pass = ~w_z & (w_n == w_v);
            LE:      o_pass = w_z | (w_n != w_v);
            AL:      o_pass = 1'b1;
            default: o_pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_unit.sv
// NZCV status register with same-cycle forwarding of committing flags,
// a pending flag-writer counter and the ID-stage stall/condition check.
module flag_unit
    import flag_unit_pkg::*;
#(
    parameter int MAX_INFLIGHT = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_issue_valid,
    input  logic       i_issue_sets_flags,
    input  logic [3:0] i_cond,
    input  logic       i_commit_valid,
    input  logic [3:0] i_alu_status,
    output logic [3:0] o_nzcv,
    output logic       o_carry,
    output logic       o_cond_pass,
    output logic       o_stall,
    output logic       o_err
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);

    logic [CW-1:0] r_count;
    logic [3:0]    r_nzcv;
    logic          r_err;

    logic [CW-1:0] w_rem;
    logic [CW-1:0] w_count_next;
    logic [3:0]    w_eff;
    logic          w_stall;
    logic          w_acc;
    logic          w_inc;
    logic          w_underflow;

    assign w_eff       = i_commit_valid ? i_alu_status : r_nzcv;
    assign w_underflow = i_commit_valid && (r_count == '0);

    // A stray commit with nothing pending must not make rem look non-zero.
    assign w_rem = (i_commit_valid && !w_underflow) ? r_count - CW'(1) : r_count;

    assign w_stall = ((w_rem != '0) && (i_cond != AL))
                   || ((r_count == MAX_CNT) && i_issue_sets_flags && !i_commit_valid);

    assign w_acc = i_issue_valid & ~w_stall;
    assign w_inc = w_acc & i_issue_sets_flags;

    assign w_count_next = w_underflow ? '0
                        : r_count + CW'(w_inc) - CW'(i_commit_valid);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
            r_nzcv  <= 4'b0000;
            r_err   <= 1'b0;
        end else begin
            r_count <= w_count_next;
            if (i_commit_valid) begin
                r_nzcv <= i_alu_status;
            end
            if (w_underflow) begin
                r_err <= 1'b1;
            end
        end
    end

    cond_eval u_cond_eval (
        .i_cond (i_cond),
        .i_nzcv (w_eff),
        .o_pass (o_cond_pass)
    );

    assign o_nzcv  = r_nzcv;
    assign o_carry = r_nzcv[C_BIT];
    assign o_stall = w_stall;
    assign o_err   = r_err;

endmodule

// File: tb/tb_flag_unit.sv
// Scoreboard bench for flag_unit: stimulus pushes expected outputs per cycle,
// a monitor pops and compares them on the falling edge.
module tb_flag_unit;
    import flag_unit_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       issue_valid = 1'b0;
    logic       issue_sets_flags = 1'b0;
    logic [3:0] cond = 4'b0000;
    logic       commit_valid = 1'b0;
    logic [3:0] alu_status = 4'b0000;
    logic [3:0] nzcv;
    logic       carry;
    logic       cond_pass;
    logic       stall;
    logic       err;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        string      name;
        logic [3:0] nzcv;
        logic       stall;
        logic       cpass;
        logic       chk_cp;
        logic       err;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    flag_unit #(.MAX_INFLIGHT(3)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_issue_valid      (issue_valid),
        .i_issue_sets_flags (issue_sets_flags),
        .i_cond             (cond),
        .i_commit_valid     (commit_valid),
        .i_alu_status       (alu_status),
        .o_nzcv             (nzcv),
        .o_carry            (carry),
        .o_cond_pass        (cond_pass),
        .o_stall            (stall),
        .o_err              (err)
    );

    // Reference condition table: even encodings are a base predicate, odd ones its inverse.
    function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, b;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0:    b = z;
            3'd1:    b = cy;
            3'd2:    b = n;
            3'd3:    b = v;
            3'd4:    b = cy & ~z;
            3'd5:    b = (n == v);
            3'd6:    b = ~z & (n == v);
            default: b = 1'b1;
        endcase
        return b ^ c[0];
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic sf, input logic [3:0] c,
                         input logic cv, input logic [3:0] st);
        issue_valid      = iv;
        issue_sets_flags = sf;
        cond             = c;
        commit_valid     = cv;
        alu_status       = st;
    endtask

    task automatic expect_out(input string nm, input logic [3:0] nz, input logic st,
                              input logic cp, input logic e);
        exp_t x;
        x.name = nm; x.nzcv = nz; x.stall = st; x.cpass = cp; x.chk_cp = ~st; x.err = e;
        sb.push_back(x);
    endtask

    task automatic step(input string nm, input logic iv, input logic sf, input logic [3:0] c,
                        input logic cv, input logic [3:0] st,
                        input logic [3:0] e_nz, input logic e_stall, input logic e_cp,
                        input logic e_err);
        cycle();
        drive(iv, sf, c, cv, st);
        expect_out(nm, e_nz, e_stall, e_cp, e_err);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                n_chk++;
                if (nzcv !== e.nzcv || carry !== e.nzcv[1] || stall !== e.stall ||
                    err !== e.err || (e.chk_cp && cond_pass !== e.cpass)) begin
                    n_err++;
                    $display("FAIL %s: got nzcv=%b carry=%b stall=%b pass=%b err=%b, want nzcv=%b carry=%b stall=%b pass=%b err=%b",
                             e.name, nzcv, carry, stall, cond_pass, err,
                             e.nzcv, e.nzcv[1], e.stall, e.cpass, e.err);
                end
            end
        end
    end

    logic [3:0] pats [5];
    logic [3:0] prev;

    initial begin
        pats[0] = 4'b0000; pats[1] = 4'b0100; pats[2] = 4'b1001;
        pats[3] = 4'b0110; pats[4] = 4'b1111;

        drive(0, 0, EQ, 0, 4'b0000);
        expect_out("reset_state", 4'b0000, 0, 0, 0);
        cycle();
        cycle();
        rst = 1'b0;

        // Commit with nothing pending: forwarded pass, then sticky err.
        step("err_commit", 0, 0, EQ, 1, 4'b0100, 4'b0000, 0, 1, 0);
        step("err_set",    0, 0, EQ, 0, 4'b0000, 4'b0100, 0, 1, 1);
        step("err_sticky", 0, 0, NE, 0, 4'b0000, 4'b0100, 0, 0, 1);
        cycle();
        rst = 1'b1;
        drive(0, 0, NE, 0, 4'b0000);
        expect_out("err_clear", 4'b0000, 0, 1, 0);
        cycle();
        rst = 1'b0;

        // Dependent condition stalls until the writer commits, then forwards.
        step("iss_s",     1, 1, AL, 0, 4'b0000, 4'b0000, 0, 1, 0);
        step("dep_stall", 1, 0, EQ, 0, 4'b0000, 4'b0000, 1, 0, 0);
        step("dep_hold",  1, 0, EQ, 0, 4'b0000, 4'b0000, 1, 0, 0);
        step("fwd_pass",  1, 0, EQ, 1, 4'b0100, 4'b0000, 0, 1, 0);
        step("fwd_nzcv",  0, 0, EQ, 0, 4'b0000, 4'b0100, 0, 1, 0);

        // AL at count 2, then fill to MAX_INFLIGHT and exercise the full case.
        step("s1",          1, 1, AL, 0, 4'b0000, 4'b0100, 0, 1, 0);
        step("s2",          1, 1, AL, 0, 4'b0000, 4'b0100, 0, 1, 0);
        step("al_cnt2",     1, 0, AL, 0, 4'b0000, 4'b0100, 0, 1, 0);
        step("ne_cnt2",     1, 0, NE, 0, 4'b0000, 4'b0100, 1, 0, 0);
        step("s3",          1, 1, AL, 0, 4'b0000, 4'b0100, 0, 1, 0);
        step("full",        1, 1, AL, 0, 4'b0000, 4'b0100, 1, 0, 0);
        step("full_commit", 1, 1, AL, 1, 4'b1001, 4'b0100, 0, 1, 0);
        step("still_full",  1, 1, AL, 0, 4'b0000, 4'b1001, 1, 0, 0);
        step("drain",       0, 0, GE, 1, 4'b1001, 4'b1001, 1, 0, 0);
        step("pre_rst",     0, 0, EQ, 0, 4'b0000, 4'b1001, 1, 0, 0);

        // Asynchronous reset at count 2: checked before the next rising edge.
        cycle();
        rst = 1'b1;
        drive(0, 0, EQ, 0, 4'b0000);
        expect_out("async_rst", 4'b0000, 0, 0, 0);
        cycle();
        rst = 1'b0;

        // All 16 conditions against each flag pattern.
        prev = 4'b0000;
        for (int p = 0; p < 5; p++) begin
            step("sw_iss", 1, 1, AL, 0, 4'b0000, prev, 0, 1, 0);
            step("sw_fwd", 0, 0, GT, 1, pats[p], prev, 0, ref_pass(GT, pats[p]), 0);
            for (int c = 0; c < 16; c++) begin
                step($sformatf("sw_c%0d_p%b", c, pats[p]), 0, 0, 4'(c), 0, 4'b0000,
                     pats[p], 0, ref_pass(4'(c), pats[p]), 0);
            end
            prev = pats[p];
        end

        cycle();
        drive(0, 0, AL, 0, 4'b0000);
        @(negedge clk);
        #1;
        n_chk++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d pending entries, want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
